// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control unit. A registered FSM steps through fetch, decode,
// execute, memory and writeback, with memory wait states. It also provides
// j/jal/jr, a sticky illegal-opcode trap and a retired-instruction counter.
module mips_multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 32,
  parameter int EN_JAL   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_src,
  output logic                illegal,
  output logic                instr_done,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_R_EXEC   = 4'd2;
  localparam logic [3:0] S_R_WB     = 4'd3;
  localparam logic [3:0] S_I_EXEC   = 4'd4;
  localparam logic [3:0] S_I_WB     = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_LW_WB    = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_JR       = 4'd11;
  localparam logic [3:0] S_J        = 4'd12;
  localparam logic [3:0] S_JAL      = 4'd13;
  localparam logic [3:0] S_TRAP     = 4'd14;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(6'b000011);

  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_NOR = FUNCT_W'(6'b100111);
  localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] FN_JR  = FUNCT_W'(6'b001000);

  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b111);

  logic [3:0]       state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Next-state selection; decode dispatches on opcode/funct held in the IR
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADD || funct == FN_AND ||
                funct == FN_NOR || funct == FN_SLT) state_d = S_R_EXEC;
            else if (funct == FN_JR)               state_d = S_JR;
            else                                    state_d = S_TRAP;
          end
          OP_ADDI, OP_ANDI: state_d = S_I_EXEC;
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_BEQ:           state_d = S_BEQ;
          OP_J:             state_d = (EN_JAL != 0) ? S_J   : S_TRAP;
          OP_JAL:           state_d = (EN_JAL != 0) ? S_JAL : S_TRAP;
          default:          state_d = S_TRAP;
        endcase
      end
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_LW_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      S_R_WB, S_I_WB, S_LW_WB, S_BEQ, S_JR, S_J, S_JAL: state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Control outputs decoded from the state; strobes are forced low while in reset
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        case (funct)
          FN_AND:  alu_op = ALU_AND;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_R_WB: begin
        reg_dst    = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
      end
      S_I_WB, S_LW_WB: begin
        mem_to_reg = (state_q == S_LW_WB) ? 2'b01 : 2'b00;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WR: begin
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_BEQ: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      S_JR, S_J, S_JAL: begin
        pc_src     = (state_q == S_JR) ? 2'b11 : 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        if (state_q == S_JAL) begin
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
          reg_write  = 1'b1;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  // Sticky trap flag and free-running wrap-around retire counter
  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
    retired_d = instr_done ? retired_q + CNT_W'(1) : retired_q;
  end

  // State, trap and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class
// cycle by cycle and checks control outputs against hand-written vectors.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;

  // default-parameter instance
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, alu_src_a;
  logic       illegal, instr_done;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [31:0] retired;

  // EN_JAL=0 instance
  logic       n_pc_write, n_ir_write, n_i_or_d, n_mem_read, n_mem_write, n_reg_write, n_alu_src_a;
  logic       n_illegal, n_instr_done;
  logic [1:0] n_reg_dst, n_mem_to_reg, n_alu_src_b, n_pc_src;
  logic [2:0] n_alu_op;
  logic [31:0] n_retired;

  // CNT_W=4 instance
  logic       w_pc_write, w_ir_write, w_i_or_d, w_mem_read, w_mem_write, w_reg_write, w_alu_src_a;
  logic       w_illegal, w_instr_done;
  logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_src_b, w_pc_src;
  logic [2:0] w_alu_op;
  logic [3:0] w_retired;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .illegal(illegal), .instr_done(instr_done), .retired(retired)
  );

  mips_multicycle_control #(.EN_JAL(0)) dut_nj (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(n_pc_write), .ir_write(n_ir_write), .i_or_d(n_i_or_d),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg),
    .reg_write(n_reg_write), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
    .pc_src(n_pc_src), .illegal(n_illegal), .instr_done(n_instr_done), .retired(n_retired)
  );

  mips_multicycle_control #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(w_pc_write), .ir_write(w_ir_write), .i_or_d(w_i_or_d),
    .mem_read(w_mem_read), .mem_write(w_mem_write), .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg),
    .reg_write(w_reg_write), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op),
    .pc_src(w_pc_src), .illegal(w_illegal), .instr_done(w_instr_done), .retired(w_retired)
  );

  logic [18:0] ctrl;
  assign ctrl = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done};

  function automatic logic [18:0] mk(int pcw, int irw, int iord, int mr, int mw, int rd,
                                     int m2r, int rw, int sa, int sb, int op, int ps, int dn);
    return {pcw[0], irw[0], iord[0], mr[0], mw[0], rd[1:0], m2r[1:0], rw[0], sa[0],
            sb[1:0], op[2:0], ps[1:0], dn[0]};
  endfunction

  task automatic chk_ctrl(input string tag, input logic [18:0] e, input logic [18:0] m);
    checks++;
    assert ((ctrl & m) === (e & m)) else begin
      failures++;
      $error("FAIL %s ctrl=%05h expected=%05h mask=%05h", tag, ctrl & m, e & m, m);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // check the current state's outputs just after the falling edge, then advance one cycle
  task automatic cyc(input string tag, input logic [18:0] e, input logic [18:0] m);
    #1;
    chk_ctrl(tag, e, m);
    @(negedge clk);
  endtask

  logic [18:0] M_STB, M_FETCH, M_FWAIT, M_EXE, M_WB, M_MEM, M_BEQ, M_JMP, M_JAL;
  logic [18:0] E_FETCH, E_FWAIT, E_DEC, E_RWB, E_IWB, E_LWB, E_MRD, E_MWRW, E_MWRD;
  logic [18:0] E_JR, E_J, E_JAL;
  logic [5:0]  fn_tab [3];
  logic [2:0]  op_tab [3];

  initial begin
    M_STB   = mk(1,1,0,1,1,0,0,1,0,0,0,0,1);
    M_FETCH = mk(1,1,1,1,1,0,0,1,1,3,7,3,1);
    M_FWAIT = mk(1,1,1,1,1,0,0,1,1,3,7,0,1);
    M_EXE   = mk(1,1,0,1,1,0,0,1,1,3,7,0,1);
    M_WB    = mk(1,1,0,1,1,3,3,1,0,0,0,0,1);
    M_MEM   = mk(1,1,1,1,1,0,0,1,0,0,0,0,1);
    M_BEQ   = mk(1,1,0,1,1,0,0,1,1,3,7,3,1);
    M_JMP   = mk(1,1,0,1,1,0,0,1,0,0,0,3,1);
    M_JAL   = mk(1,1,0,1,1,3,3,1,0,0,0,3,1);
    E_FETCH = mk(1,1,0,1,0,0,0,0,0,1,2,0,0);
    E_FWAIT = mk(0,0,0,1,0,0,0,0,0,1,2,0,0);
    E_DEC   = mk(0,0,0,0,0,0,0,0,0,3,2,0,0);
    E_RWB   = mk(0,0,0,0,0,1,0,1,0,0,0,0,1);
    E_IWB   = mk(0,0,0,0,0,0,0,1,0,0,0,0,1);
    E_LWB   = mk(0,0,0,0,0,0,1,1,0,0,0,0,1);
    E_MRD   = mk(0,0,1,1,0,0,0,0,0,0,0,0,0);
    E_MWRW  = mk(0,0,1,0,1,0,0,0,0,0,0,0,0);
    E_MWRD  = mk(0,0,1,0,1,0,0,0,0,0,0,0,1);
    E_JR    = mk(1,0,0,0,0,0,0,0,0,0,0,3,1);
    E_J     = mk(1,0,0,0,0,0,0,0,0,0,0,2,1);
    E_JAL   = mk(1,0,0,0,0,2,2,1,0,0,0,2,1);
    fn_tab  = '{6'b100100, 6'b100111, 6'b101010};
    op_tab  = '{3'b000, 3'b011, 3'b111};

    // reset: strobes low even with mem_ready high in FETCH
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk_ctrl("rst_strobes", '0, M_STB);
    chk_val("rst_illegal", {31'b0, illegal}, 32'd0);
    chk_val("rst_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add
    opcode = 6'b000000; funct = 6'b100000;
    cyc("add_fetch", E_FETCH, M_FETCH);
    cyc("add_decode", E_DEC, M_EXE);
    cyc("add_exec", mk(0,0,0,0,0,0,0,0,1,0,2,0,0), M_EXE);
    cyc("add_wb", E_RWB, M_WB);
    chk_val("add_retired", retired, 32'd1);

    // lw with three wait cycles in MEM_RD
    opcode = 6'b100011;
    cyc("lw_fetch", E_FETCH, M_FETCH);
    cyc("lw_decode", E_DEC, M_EXE);
    cyc("lw_addr", mk(0,0,0,0,0,0,0,0,1,2,2,0,0), M_EXE);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", E_MRD, M_MEM);
    mem_ready = 1'b1;
    cyc("lw_rd_done", E_MRD, M_MEM);
    cyc("lw_wb", E_LWB, M_WB);
    chk_val("lw_retired", retired, 32'd2);

    // beq not taken then taken
    opcode = 6'b000100; zero = 1'b0;
    cyc("beq0_fetch", E_FETCH, M_FETCH);
    cyc("beq0_decode", E_DEC, M_EXE);
    cyc("beq0_exec", mk(0,0,0,0,0,0,0,0,1,0,6,1,1), M_BEQ);
    zero = 1'b1;
    cyc("beq1_fetch", E_FETCH, M_FETCH);
    cyc("beq1_decode", E_DEC, M_EXE);
    cyc("beq1_exec", mk(1,0,0,0,0,0,0,0,1,0,6,1,1), M_BEQ);
    chk_val("beq_retired", retired, 32'd4);
    zero = 1'b0;

    // jal: decoded by default instance, trapped by the EN_JAL=0 instance
    opcode = 6'b000011;
    cyc("jal_fetch", E_FETCH, M_FETCH);
    cyc("jal_decode", E_DEC, M_EXE);
    cyc("jal_exec", E_JAL, M_JAL);
    chk_val("jal_retired", retired, 32'd5);
    chk_val("jal_illegal", {31'b0, illegal}, 32'd0);
    chk_val("nj_illegal", {31'b0, n_illegal}, 32'd1);
    chk_val("nj_retired", n_retired, 32'd4);

    // j
    opcode = 6'b000010;
    cyc("j_fetch", E_FETCH, M_FETCH);
    cyc("j_decode", E_DEC, M_EXE);
    cyc("j_exec", E_J, M_JMP);
    chk_val("j_retired", retired, 32'd6);
    chk_val("nj_stuck_retired", n_retired, 32'd4);
    chk_val("nj_stuck_strobe", {31'b0, n_pc_write | n_mem_read}, 32'd0);

    // and, nor, slt
    opcode = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      funct = fn_tab[i];
      cyc("r_fetch", E_FETCH, M_FETCH);
      cyc("r_decode", E_DEC, M_EXE);
      cyc("r_exec", mk(0,0,0,0,0,0,0,0,1,0,int'(op_tab[i]),0,0), M_EXE);
      cyc("r_wb", E_RWB, M_WB);
    end
    chk_val("r_retired", retired, 32'd9);

    // addi, andi
    opcode = 6'b001000;
    cyc("addi_fetch", E_FETCH, M_FETCH);
    cyc("addi_decode", E_DEC, M_EXE);
    cyc("addi_exec", mk(0,0,0,0,0,0,0,0,1,2,2,0,0), M_EXE);
    cyc("addi_wb", E_IWB, M_WB);
    opcode = 6'b001100;
    cyc("andi_fetch", E_FETCH, M_FETCH);
    cyc("andi_decode", E_DEC, M_EXE);
    cyc("andi_exec", mk(0,0,0,0,0,0,0,0,1,2,0,0,0), M_EXE);
    cyc("andi_wb", E_IWB, M_WB);
    chk_val("i_retired", retired, 32'd11);

    // sw with one wait cycle, preceded by a fetch wait
    opcode = 6'b101011; mem_ready = 1'b0;
    cyc("sw_fetch_wait", E_FWAIT, M_FWAIT);
    mem_ready = 1'b1;
    cyc("sw_fetch", E_FETCH, M_FETCH);
    cyc("sw_decode", E_DEC, M_EXE);
    cyc("sw_addr", mk(0,0,0,0,0,0,0,0,1,2,2,0,0), M_EXE);
    mem_ready = 1'b0;
    cyc("sw_wait", E_MWRW, M_MEM);
    mem_ready = 1'b1;
    cyc("sw_done", E_MWRD, M_MEM);
    chk_val("sw_retired", retired, 32'd12);

    // jr
    opcode = 6'b000000; funct = 6'b001000;
    cyc("jr_fetch", E_FETCH, M_FETCH);
    cyc("jr_decode", E_DEC, M_EXE);
    cyc("jr_exec", E_JR, M_JMP);
    chk_val("jr_retired", retired, 32'd13);

    // illegal opcode traps until reset
    opcode = 6'b111111;
    cyc("ill_fetch", E_FETCH, M_FETCH);
    cyc("ill_decode", E_DEC, M_EXE);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk_val("trap_illegal", {31'b0, illegal}, 32'd1);
      chk_ctrl("trap_strobes", '0, M_STB);
      @(negedge clk);
    end
    chk_val("trap_retired", retired, 32'd13);
    rst_n = 1'b0;
    #1;
    chk_val("trap_clear", {31'b0, illegal}, 32'd0);
    chk_val("trap_rst_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 17 jr on the 4-bit counter instance: 15, 0, 1
    opcode = 6'b000000; funct = 6'b001000;
    for (int k = 1; k <= 17; k++) begin
      cyc("wrap_fetch", E_FETCH, M_FETCH);
      cyc("wrap_decode", E_DEC, M_EXE);
      cyc("wrap_jr", E_JR, M_JMP);
      if (k >= 15) chk_val("wrap_retired", {28'b0, w_retired}, 32'(k % 16));
    end
    chk_val("nowrap_retired", retired, 32'd17);

    // reset asserted mid sw wait: mem_write drops before any clock edge
    opcode = 6'b101011;
    cyc("swr_fetch", E_FETCH, M_FETCH);
    cyc("swr_decode", E_DEC, M_EXE);
    cyc("swr_addr", mk(0,0,0,0,0,0,0,0,1,2,2,0,0), M_EXE);
    mem_ready = 1'b0;
    cyc("swr_wait", E_MWRW, M_MEM);
    @(posedge clk);
    #2;
    chk_val("swr_mw_before", {31'b0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_val("swr_mw_dropped", {31'b0, mem_write}, 32'd0);
    chk_val("swr_clk_high", {31'b0, clk}, 32'd1);
    chk_val("swr_retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    cyc("post_fetch", E_FETCH, M_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
